// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the BCD counter family.
// Digit limits, the digit type and a digit-validity check.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic is_bcd(bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with parallel load.
// Borrows upward when asked to decrement from zero.
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_in,
    input  logic       load,
    input  bcd_digit_t ld_digit,
    output bcd_digit_t q,
    output logic       borrow
);

    assign borrow = dec_in & (q == BCD_ZERO);

    // Digit register: reset, load, or decrement with 0 -> 9 roll-under
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else if (load) begin
            q <= ld_digit;
        end else if (dec_in) begin
            q <= (q == BCD_ZERO) ? BCD_MAX : q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with validated parallel load.
// Define BCD_DOWN_RELOAD_EN to wrap to the last loaded value instead of all 9s.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                zero,
    output logic                borrow_out,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    logic            valid;
    logic            ld_ok;
    logic            wrap;
    logic            wrap_zero;
    logic            dig_load;
    logic [W-1:0]    ld_src;
    logic [DIGITS:0] chain;

    // A load is accepted only when every digit is a legal BCD value
    always_comb begin
        valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            valid &= is_bcd(load_val[4*i +: 4]);
        end
    end

    assign ld_ok    = load & valid;
    assign chain[0] = en & ~load;
    assign wrap     = chain[DIGITS];

`ifdef BCD_DOWN_RELOAD_EN
    logic [W-1:0] reload_q;

    // Reload value tracks every accepted load; all 9s after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= {DIGITS{BCD_MAX}};
        end else if (ld_ok) begin
            reload_q <= load_val;
        end
    end

    assign dig_load  = ld_ok | wrap;
    assign ld_src    = ld_ok ? load_val : reload_q;
    assign wrap_zero = (reload_q == '0);
`else
    assign dig_load  = ld_ok;
    assign ld_src    = load_val;
    assign wrap_zero = 1'b0;
`endif

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        bcd_digit_t q;

        bcd_digit_down u_dig (
            .clk      (clk),
            .rst      (rst),
            .dec_in   (chain[i]),
            .load     (dig_load),
            .ld_digit (ld_src[4*i +: 4]),
            .q        (q),
            .borrow   (chain[i+1])
        );

        assign count[4*i +: 4] = q;
    end

    assign borrow_out = en & (count == '0);

    // Zero flag follows the next count; load_err pulses on a rejected load
    always_ff @(posedge clk) begin
        if (rst) begin
            zero     <= 1'b1;
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~valid;
            if (ld_ok) begin
                zero <= (load_val == '0);
            end else if (wrap) begin
                zero <= wrap_zero;
            end else if (chain[0]) begin
                zero <= (count == W'(1));
            end
        end
    end

endmodule
